// File: rtl/store_cache_controller_multi.sv
// store_cache_controller_multi: in-order speculative store queue feeding a set-associative cache port with invalidate service
module store_cache_controller_multi #(
  parameter int ADDR_W      = 32,
  parameter int PORT_BYTES  = 4,
  parameter int WAYS        = 2,
  parameter int ID_W        = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   stu_valid_i,
  output logic                                   stu_ready_o,
  input  logic [ADDR_W-1:0]                      stu_address_i,
  input  logic [8*PORT_BYTES-1:0]                stu_data_i,
  input  logic [1:0]                             stu_width_i,
  input  logic                                   stu_cachable_i,
  input  logic                                   stu_bufferable_i,
  input  logic                                   stu_speculative_i,
  input  logic [ID_W-1:0]                        stu_spec_id_i,
  input  logic                                   spec_resolved_i,
  input  logic [ID_W-1:0]                        spec_id_i,
  input  logic                                   spec_kill_i,
  input  logic                                   ext_invalidate_i,
  input  logic [ADDR_W-$clog2(PORT_BYTES)-1:0]   ext_address_i,
  input  logic                                   ext_acknowledge_i,
  output logic                                   cpu_acknowledge_o,
  output logic                                   cpu_request_o,
  output logic                                   port0_request_o,
  input  logic                                   port0_granted_i,
  input  logic                                   hit_i,
  input  logic [WAYS-1:0]                        way_hit_i,
  output logic                                   cache_read_o,
  output logic                                   cache_write_o,
  output logic [ADDR_W-$clog2(PORT_BYTES)-1:0]   cache_address_o,
  output logic [PORT_BYTES-1:0]                  cache_byte_write_o,
  output logic [8*PORT_BYTES-1:0]                cache_data_o,
  output logic [WAYS-1:0]                        cache_enable_way_o,
  output logic [3:0]                             cache_enable_o,
  output logic                                   cache_dirty_o,
  output logic                                   cache_valid_o,
  input  logic                                   str_buf_full_i,
  output logic                                   str_buf_push_o,
  output logic [1:0]                             str_buf_width_o,
  output logic                                   done_o,
  output logic                                   idle_o
);
  localparam int OB = $clog2(PORT_BYTES);
  localparam int WA = ADDR_W - OB;
  localparam int PW = $clog2(QUEUE_DEPTH);
  typedef enum logic [2:0] {IDLE, WAIT_CACHE, COMPARE, COMPARE_INV, WRITE_DATA, MEMORY_WRITE, INVALIDATE} state_t;
  state_t state, state_n;
  logic [QUEUE_DEPTH-1:0] q_valid, q_spec, q_kill, q_cach, q_buf;
  logic [ID_W-1:0] q_id [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_addr [QUEUE_DEPTH];
  logic [8*PORT_BYTES-1:0] q_data [QUEUE_DEPTH];
  logic [1:0] q_width [QUEUE_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic inv;
  logic [WA-1:0] inv_addr;
  logic push, pop, res_hit, head_killed, head_ready;
  logic [ADDR_W-1:0] head_addr;
  logic [8*PORT_BYTES-1:0] head_data, lane_data;
  logic [1:0] head_width, lsz;
  logic [OB:0] sz;
  logic [OB-1:0] off;
  logic [PORT_BYTES-1:0] lane_be;
  assign stu_ready_o = count != (PW+1)'(QUEUE_DEPTH);
  assign push = stu_valid_i && stu_ready_o;
  assign res_hit = spec_resolved_i && stu_spec_id_i == spec_id_i;
  assign idle_o = state == IDLE && count == '0;
  assign head_addr = q_addr[head];
  assign head_data = q_data[head];
  assign head_width = q_width[head];
  assign head_killed = q_valid[head] && q_kill[head];
  assign head_ready = q_valid[head] && !q_spec[head] && !q_kill[head];
  // double-width stores on a narrow port collapse to a full-port store
  assign lsz = head_width > 2'(OB) ? 2'(OB) : head_width;
  assign sz = (OB+1)'(1) << lsz;
  assign off = head_addr[OB-1:0] & ~OB'(sz - (OB+1)'(1));
  assign lane_be = ~({PORT_BYTES{1'b1}} << sz) << off;
  assign lane_data = head_data << {off, 3'b000};
  always_comb begin
    state_n = state;
    pop = 1'b0;
    done_o = 1'b0;
    port0_request_o = 1'b0;
    cpu_acknowledge_o = 1'b0;
    cpu_request_o = 1'b0;
    cache_read_o = 1'b0;
    cache_write_o = 1'b0;
    cache_address_o = '0;
    cache_byte_write_o = '0;
    cache_data_o = '0;
    cache_enable_o = 4'b0000;
    cache_dirty_o = 1'b0;
    cache_valid_o = 1'b0;
    str_buf_push_o = 1'b0;
    str_buf_width_o = 2'b00;
    case (state)
      IDLE: begin
        if (head_killed) begin
          pop = 1'b1;
          done_o = 1'b1;
        end else if (ext_invalidate_i) begin
          port0_request_o = 1'b1;
          if (port0_granted_i) begin
            cache_read_o = 1'b1;
            cache_address_o = ext_address_i;
            cache_enable_o = 4'b0011;
            cpu_acknowledge_o = 1'b1;
            state_n = WAIT_CACHE;
          end
        end else if (head_ready && q_cach[head]) begin
          port0_request_o = 1'b1;
          if (port0_granted_i) begin
            cache_read_o = 1'b1;
            cache_address_o = head_addr[ADDR_W-1:OB];
            cache_enable_o = 4'b0011;
            state_n = WAIT_CACHE;
          end
        end else if (head_ready) state_n = MEMORY_WRITE;
      end
      WAIT_CACHE: state_n = inv ? COMPARE_INV : COMPARE;
      COMPARE: state_n = hit_i ? WRITE_DATA : MEMORY_WRITE;
      COMPARE_INV: state_n = hit_i ? INVALIDATE : IDLE;
      WRITE_DATA: begin
        port0_request_o = 1'b1;
        if (port0_granted_i) begin
          cache_write_o = 1'b1;
          cache_address_o = head_addr[ADDR_W-1:OB];
          cache_byte_write_o = lane_be;
          cache_data_o = lane_data;
          cache_enable_o = 4'b1100;
          cache_dirty_o = 1'b1;
          pop = 1'b1;
          done_o = 1'b1;
          state_n = IDLE;
        end
      end
      INVALIDATE: begin
        port0_request_o = 1'b1;
        if (port0_granted_i) begin
          cache_write_o = 1'b1;
          cache_address_o = inv_addr;
          cache_enable_o = 4'b0010;
          state_n = IDLE;
        end
      end
      MEMORY_WRITE: begin
        cache_address_o = head_addr[ADDR_W-1:OB];
        cache_data_o = lane_data;
        if (q_buf[head]) begin
          if (!str_buf_full_i) begin
            str_buf_push_o = 1'b1;
            str_buf_width_o = head_width;
            pop = 1'b1;
            done_o = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cpu_request_o = !ext_acknowledge_i;
          if (ext_acknowledge_i) begin
            pop = 1'b1;
            done_o = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      q_valid <= '0;
      q_spec <= '0;
      q_kill <= '0;
      inv <= 1'b0;
      inv_addr <= '0;
      cache_enable_way_o <= '0;
    end else begin
      state <= state_n;
      if (cpu_acknowledge_o) inv_addr <= ext_address_i;
      if (cache_read_o) inv <= cpu_acknowledge_o;
      if (state == COMPARE || state == COMPARE_INV) cache_enable_way_o <= way_hit_i;
      for (int i = 0; i < QUEUE_DEPTH; i++)
        if (spec_resolved_i && q_valid[i] && q_spec[i] && q_id[i] == spec_id_i) begin
          q_spec[i] <= 1'b0;
          q_kill[i] <= spec_kill_i;
        end
      if (push) begin
        q_valid[tail] <= 1'b1;
        q_spec[tail] <= stu_speculative_i && !res_hit;
        q_kill[tail] <= stu_speculative_i && res_hit && spec_kill_i;
        q_id[tail] <= stu_spec_id_i;
        q_addr[tail] <= stu_address_i;
        q_data[tail] <= stu_data_i;
        q_width[tail] <= stu_width_i;
        q_cach[tail] <= stu_cachable_i;
        q_buf[tail] <= stu_bufferable_i;
        tail <= tail + PW'(1);
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head <= head + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_store_cache_controller_multi.sv
// tb_store_cache_controller_multi: vector table, directed timing sequences and a random run against a transaction-level store model
module tb_store_cache_controller_multi;
  logic clk = 1'b0, rst_n_i = 1'b0;
  logic stu_valid_i = 0, stu_cachable_i = 0, stu_bufferable_i = 0, stu_speculative_i = 0;
  logic [31:0] stu_address_i = '0, stu_data_i = '0;
  logic [1:0] stu_width_i = '0, stu_spec_id_i = '0, spec_id_i = '0;
  logic spec_resolved_i = 0, spec_kill_i = 0, ext_invalidate_i = 0, ext_acknowledge_i = 0;
  logic [29:0] ext_address_i = '0;
  logic port0_granted_i = 0, hit_i, str_buf_full_i = 0;
  logic [1:0] way_hit_i;
  logic stu_ready_o, cpu_acknowledge_o, cpu_request_o, port0_request_o, cache_read_o, cache_write_o;
  logic [29:0] cache_address_o;
  logic [3:0] cache_byte_write_o, cache_enable_o;
  logic [31:0] cache_data_o;
  logic [1:0] cache_enable_way_o, str_buf_width_o;
  logic cache_dirty_o, cache_valid_o, str_buf_push_o, done_o, idle_o;

  store_cache_controller_multi dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .stu_valid_i(stu_valid_i), .stu_ready_o(stu_ready_o), .stu_address_i(stu_address_i),
    .stu_data_i(stu_data_i), .stu_width_i(stu_width_i), .stu_cachable_i(stu_cachable_i),
    .stu_bufferable_i(stu_bufferable_i), .stu_speculative_i(stu_speculative_i), .stu_spec_id_i(stu_spec_id_i),
    .spec_resolved_i(spec_resolved_i), .spec_id_i(spec_id_i), .spec_kill_i(spec_kill_i),
    .ext_invalidate_i(ext_invalidate_i), .ext_address_i(ext_address_i), .ext_acknowledge_i(ext_acknowledge_i),
    .cpu_acknowledge_o(cpu_acknowledge_o), .cpu_request_o(cpu_request_o), .port0_request_o(port0_request_o),
    .port0_granted_i(port0_granted_i), .hit_i(hit_i), .way_hit_i(way_hit_i),
    .cache_read_o(cache_read_o), .cache_write_o(cache_write_o), .cache_address_o(cache_address_o),
    .cache_byte_write_o(cache_byte_write_o), .cache_data_o(cache_data_o), .cache_enable_way_o(cache_enable_way_o),
    .cache_enable_o(cache_enable_o), .cache_dirty_o(cache_dirty_o), .cache_valid_o(cache_valid_o),
    .str_buf_full_i(str_buf_full_i), .str_buf_push_o(str_buf_push_o), .str_buf_width_o(str_buf_width_o),
    .done_o(done_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, data;
    logic [1:0] width, id;
    logic cach, bufb, spec, kill;
  } st_t;
  typedef struct {
    logic [31:0] addr, data;
    logic [1:0] w;
    logic [3:0] be;
    logic [31:0] cd;
  } vec_t;

  st_t mq[$];
  logic [29:0] iq[$];
  int n_chk = 0, n_fail = 0, ack_cnt = 0;
  logic [29:0] rd_addr = '0;

  // cache environment: a line hits when word-address bit 3 is clear; the hit way is word-address bit 0
  function automatic bit hitf(input logic [29:0] w);
    return !w[3];
  endfunction
  assign hit_i = hitf(rd_addr);
  assign way_hit_i = hit_i ? (rd_addr[0] ? 2'b10 : 2'b01) : 2'b00;
  always @(negedge clk) if (cache_read_o && port0_granted_i) rd_addr <= cache_address_o;

  function automatic int e_off(input logic [31:0] a, input logic [1:0] w);
    int sz = 1 << ((w > 2) ? 2 : int'(w));
    return (int'(a % 4) / sz) * sz;
  endfunction
  function automatic logic [3:0] e_be(input logic [31:0] a, input logic [1:0] w);
    int sz = 1 << ((w > 2) ? 2 : int'(w));
    return 4'(((1 << sz) - 1) << e_off(a, w));
  endfunction
  function automatic logic [31:0] e_cd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    return d << (8 * e_off(a, w));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction scoreboard: every store retires once, in push order, with an outcome fixed by its attributes
  always @(negedge clk) begin
    st_t e, ne;
    if (!rst_n_i) begin
      mq.delete();
      iq.delete();
    end else begin
      chk("ready", stu_ready_o, mq.size() < 4);
      if (done_o) begin
        if (mq.size() == 0) chk("done_with_empty_model", 1, 0);
        else begin
          e = mq.pop_front();
          if (e.kill) chk("killed_side_effect", {cache_write_o, str_buf_push_o}, 0);
          else if (e.cach && hitf(e.addr[31:2])) begin
            chk("hit_write", cache_write_o, 1);
            chk("hit_addr", cache_address_o, e.addr[31:2]);
            chk("hit_be", cache_byte_write_o, e_be(e.addr, e.width));
            chk("hit_data", cache_data_o, e_cd(e.addr, e.data, e.width));
            chk("hit_enable", cache_enable_o, 4'b1100);
            chk("hit_dirty", cache_dirty_o, 1);
            chk("hit_way", cache_enable_way_o, e.addr[2] ? 2'b10 : 2'b01);
          end else if (e.bufb) begin
            chk("buf_push", str_buf_push_o, 1);
            chk("buf_width", str_buf_width_o, e.width);
            chk("buf_not_full", str_buf_full_i, 0);
          end else begin
            chk("mem_ack", ext_acknowledge_i, 1);
            chk("mem_side_effect", {cache_write_o, str_buf_push_o, cpu_request_o}, 0);
          end
        end
      end else if (cache_write_o) begin
        if (iq.size() == 0) chk("inv_write_unexpected", 1, 0);
        else begin
          chk("inv_addr", cache_address_o, iq.pop_front());
          chk("inv_enable", cache_enable_o, 4'b0010);
          chk("inv_valid", cache_valid_o, 0);
        end
      end else if (str_buf_push_o) chk("push_without_done", 1, 0);
      if (cpu_acknowledge_o) begin
        ack_cnt++;
        if (hitf(ext_address_i)) iq.push_back(ext_address_i);
      end
      if (stu_valid_i && stu_ready_o) begin
        ne.addr = stu_address_i; ne.data = stu_data_i; ne.width = stu_width_i; ne.id = stu_spec_id_i;
        ne.cach = stu_cachable_i; ne.bufb = stu_bufferable_i; ne.spec = stu_speculative_i; ne.kill = 0;
        mq.push_back(ne);
      end
      if (spec_resolved_i)
        foreach (mq[i]) if (mq[i].spec && mq[i].id == spec_id_i) begin
          mq[i].spec = 0;
          mq[i].kill = spec_kill_i;
        end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                      input logic c, input logic b, input logic s, input logic [1:0] id);
    stu_address_i = a; stu_data_i = d; stu_width_i = w; stu_cachable_i = c;
    stu_bufferable_i = b; stu_speculative_i = s; stu_spec_id_i = id; stu_valid_i = 1;
    cyc();
    stu_valid_i = 0;
  endtask
  task automatic wait_write(input string nm, input int lim);
    int k = 0;
    smp();
    while (!cache_write_o && k < lim) begin
      cyc();
      smp();
      k++;
    end
    if (!cache_write_o) chk(nm, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int rdc, wrc, dnc, last_ack;
    logic [3:0] be;
    tbl[0] = '{32'h100, 32'hDEADBEEF, 2'd2, 4'hF, 32'hDEADBEEF};
    tbl[1] = '{32'h103, 32'h000000AB, 2'd0, 4'h8, 32'hAB000000};
    tbl[2] = '{32'h102, 32'h00001234, 2'd1, 4'hC, 32'h12340000};
    tbl[3] = '{32'h101, 32'h00001234, 2'd1, 4'h3, 32'h00001234};
    tbl[4] = '{32'h105, 32'hCAFEF00D, 2'd2, 4'hF, 32'hCAFEF00D};
    tbl[5] = '{32'h106, 32'h01020304, 2'd3, 4'hF, 32'h01020304};
    tbl[6] = '{32'h081, 32'h0000005A, 2'd0, 4'h2, 32'h00005A00};
    tbl[7] = '{32'h0C2, 32'h00000077, 2'd0, 4'h4, 32'h00770000};
    cyc();
    smp();
    chk("rst_ready_idle", {stu_ready_o, idle_o}, 2'b11);
    chk("rst_ctrl", {cpu_acknowledge_o, cpu_request_o, port0_request_o, cache_read_o, cache_write_o,
                     cache_dirty_o, cache_valid_o, str_buf_push_o, done_o}, 0);
    chk("rst_addr_data", {cache_address_o, cache_data_o}, 0);
    chk("rst_be_en_way", {cache_byte_write_o, cache_enable_o, cache_enable_way_o, str_buf_width_o}, 0);
    cyc();
    rst_n_i = 1;
    port0_granted_i = 1;
    smp();
    chk("post_rst_idle", {stu_ready_o, idle_o, port0_request_o}, 3'b110);
    cyc();
    // word store timing: read in cycle 0, write and retire in cycle 3
    push(32'h100, 32'hDEADBEEF, 2'd2, 1, 1, 0, 0);
    rdc = -1; wrc = -1; dnc = -1; be = '0;
    for (int c = 0; c < 6; c++) begin
      smp();
      if (cache_read_o && rdc < 0) rdc = c;
      if (cache_write_o && wrc < 0) begin wrc = c; be = cache_byte_write_o; end
      if (done_o && dnc < 0) dnc = c;
      cyc();
    end
    chk("t1_read_cycle", rdc, 0);
    chk("t1_write_cycle", wrc, 3);
    chk("t1_done_cycle", dnc, 3);
    chk("t1_be", be, 4'hF);
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].addr, tbl[i].data, tbl[i].w, 1, 1, 0, 0);
      wait_write("tbl_write_seen", 10);
      chk("tbl_be", cache_byte_write_o, tbl[i].be);
      chk("tbl_data", cache_data_o, tbl[i].cd);
      cyc();
    end
    // four speculative stores fill the queue, then a kill drains them
    stu_valid_i = 1; stu_speculative_i = 1; stu_spec_id_i = 1; stu_cachable_i = 1; stu_width_i = 2;
    for (int i = 0; i < 4; i++) begin
      stu_address_i = 32'h200 + 32'(4 * i);
      cyc();
    end
    stu_valid_i = 0;
    smp();
    chk("kill_full_ready", stu_ready_o, 0);
    cyc();
    spec_resolved_i = 1; spec_id_i = 1; spec_kill_i = 1;
    smp();
    chk("kill_not_yet", done_o, 0);
    cyc();
    spec_resolved_i = 0; spec_kill_i = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("kill_done", done_o, 1);
      chk("kill_no_write", cache_write_o, 0);
      cyc();
    end
    smp();
    chk("kill_idle", {idle_o, done_o}, 2'b10);
    cyc();
    // resolution in the same cycle as the push
    spec_resolved_i = 1; spec_id_i = 2; spec_kill_i = 0;
    push(32'h140, 32'h0BADCAFE, 2'd2, 1, 1, 1, 2);
    spec_resolved_i = 0;
    wait_write("samecyc_write", 10);
    chk("samecyc_done", done_o, 1);
    cyc();
    // invalidation takes priority over a pending store
    port0_granted_i = 0;
    push(32'h100, 32'h11223344, 2'd2, 1, 1, 0, 0);
    smp();
    chk("inv_pre_req", {port0_request_o, cache_read_o}, 2'b10);
    cyc();
    ext_invalidate_i = 1; ext_address_i = 30'h44; port0_granted_i = 1;
    smp();
    chk("inv_ack", {cpu_acknowledge_o, cache_read_o}, 2'b11);
    chk("inv_read_addr", cache_address_o, 30'h44);
    cyc();
    ext_invalidate_i = 0;
    wait_write("inv_write_seen", 10);
    chk("inv_wr_fields", {cache_address_o, cache_enable_o, cache_valid_o, done_o}, {30'h44, 4'b0010, 1'b0, 1'b0});
    cyc();
    wait_write("inv_store_write", 10);
    chk("inv_store_fields", {cache_address_o, done_o}, {30'h40, 1'b1});
    cyc();
    // non-bufferable miss waits for the memory acknowledge
    push(32'h120, 32'h55, 2'd2, 1, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      smp();
      chk("nb_req", cpu_request_o, c >= 3);
      chk("nb_no_done", done_o, 0);
      cyc();
    end
    ext_acknowledge_i = 1;
    smp();
    chk("nb_done", {done_o, cpu_request_o}, 2'b10);
    cyc();
    ext_acknowledge_i = 0;
    // bufferable miss stalls while the store buffer is full
    str_buf_full_i = 1;
    push(32'h120, 32'h66, 2'd1, 1, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      smp();
      chk("bf_stall", {str_buf_push_o, done_o}, 0);
      cyc();
    end
    str_buf_full_i = 0;
    smp();
    chk("bf_push", {str_buf_push_o, done_o, str_buf_width_o}, {1'b1, 1'b1, 2'd1});
    cyc();
    last_ack = ack_cnt;
    for (int c = 0; c < 4000; c++) begin
      stu_valid_i = ($urandom % 3) == 0;
      stu_address_i = $urandom & 32'h1FF;
      stu_data_i = $urandom;
      stu_width_i = 2'($urandom);
      stu_cachable_i = ($urandom % 4) != 0;
      stu_bufferable_i = 1'($urandom);
      stu_speculative_i = 1'($urandom);
      stu_spec_id_i = 2'($urandom);
      spec_resolved_i = ($urandom % 4) == 0;
      spec_id_i = 2'($urandom);
      spec_kill_i = ($urandom % 3) == 0;
      if (ext_invalidate_i && ack_cnt != last_ack) ext_invalidate_i = 0;
      else if (!ext_invalidate_i && ($urandom % 16) == 0) begin
        ext_invalidate_i = 1;
        ext_address_i = 30'($urandom & 32'h7F);
      end
      last_ack = ack_cnt;
      port0_granted_i = ($urandom % 4) != 0;
      str_buf_full_i = ($urandom % 3) == 0;
      ext_acknowledge_i = ($urandom % 3) == 0;
      cyc();
    end
    for (int c = 0; c < 400; c++) begin
      stu_valid_i = 0; ext_invalidate_i = 0; port0_granted_i = 1; str_buf_full_i = 0; ext_acknowledge_i = 1;
      spec_resolved_i = 1; spec_id_i = 2'(c); spec_kill_i = 0;
      smp();
      if (idle_o && mq.size() == 0) break;
      cyc();
    end
    spec_resolved_i = 0;
    chk("drain_idle", idle_o, 1);
    chk("drain_model_empty", mq.size(), 0);
    chk("drain_inv_empty", iq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_cache_controller_multi.md
Name: store_cache_controller_multi

Overview:
Parametrised store-side data-cache controller. A QUEUE_DEPTH-entry in-order store queue holds multiple outstanding (possibly speculative) stores between the store unit and cache port 0; speculation is resolved per entry by ID. It serves external invalidation requests with priority, and generalises way count, port width and access width (byte/half/word/double).

Parameters:
ADDR_W, 32, byte address width
PORT_BYTES, 4, cache port width in bytes (power of 2, 4 or 8)
WAYS, 2, cache associativity
ID_W, 2, speculative ID width
QUEUE_DEPTH, 4, store queue entries (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
stu_valid_i  in  1  store request valid
stu_ready_o  out  1  queue not full; push when valid&ready
stu_address_i  in  ADDR_W  byte address
stu_data_i  in  8*PORT_BYTES  store data, right-aligned
stu_width_i  in  2  0 byte, 1 half, 2 word, 3 double
stu_cachable_i  in  1  cachable region
stu_bufferable_i  in  1  bufferable region
stu_speculative_i  in  1  store is speculative
stu_spec_id_i  in  ID_W  speculative ID
spec_resolved_i  in  1  resolution event
spec_id_i  in  ID_W  resolved ID
spec_kill_i  in  1  resolution is a kill
ext_invalidate_i  in  1  invalidate request
ext_address_i  in  ADDR_W-log2(PORT_BYTES)  invalidate word address
ext_acknowledge_i  in  1  memory accepted non-bufferable store
cpu_acknowledge_o  out  1  invalidate accepted
cpu_request_o  out  1  non-bufferable store request
port0_request_o  out  1  port 0 request
port0_granted_i  in  1  port 0 grant
hit_i  in  1  tag hit, valid in COMPARE
way_hit_i  in  WAYS  one-hot hit way
cache_read_o, cache_write_o  out  1  cache strobes
cache_address_o  out  ADDR_W-log2(PORT_BYTES)  word address
cache_byte_write_o  out  PORT_BYTES  byte enables
cache_data_o  out  8*PORT_BYTES  lane-aligned data
cache_enable_way_o  out  WAYS  latched hit way
cache_enable_o  out  4  {data, dirty, valid, tag}
cache_dirty_o, cache_valid_o  out  1  bit values written
str_buf_full_i  in  1  store buffer full
str_buf_push_o  out  1  push into store buffer
str_buf_width_o  out  2  width of pushed store
done_o  out  1  one-cycle pulse per retired or killed store
idle_o  out  1  state IDLE and queue empty

Behaviour:
- Reset (sync, rst_n_i=0 at posedge): queue empty, state IDLE, cache_enable_way_o=0; all combinational outputs 0, except stu_ready_o=1 and idle_o=1.
- Queue entry: {valid, spec, id, addr, data, width, cachable, bufferable}. Push on stu_valid_i&stu_ready_o; stu_ready_o = !full. Pop only from head. Wrap via log2(QUEUE_DEPTH) pointers plus count.
- Resolution: on spec_resolved_i, every valid entry with spec=1 and id==spec_id_i gets spec cleared (kill=0) or becomes killed (kill=1). An entry pushed in the same cycle with matching ID is affected identically.
- FSM states: IDLE, WAIT_CACHE, COMPARE, COMPARE_INV, WRITE_DATA, MEMORY_WRITE, INVALIDATE.
- IDLE: priority 1) head killed -> pop, done_o=1, stay IDLE, no port request. 2) ext_invalidate_i -> port0_request_o=1; on grant: cache_read_o=1, cache_address_o=ext_address_i, enable tag|valid, cpu_acknowledge_o=1, latch address, go WAIT_CACHE (inv flag set). 3) head valid, spec=0: cachable -> request port; on grant read tag|valid at head word address -> WAIT_CACHE; non-cachable -> MEMORY_WRITE with no port request.
- WAIT_CACHE: one cycle -> COMPARE (store) or COMPARE_INV (inv).
- COMPARE: latch way_hit_i; hit -> WRITE_DATA, miss -> MEMORY_WRITE (no write-allocate).
- COMPARE_INV: latch way; hit -> INVALIDATE, miss -> IDLE.
- WRITE_DATA: request port; on grant: cache_write_o=1, enable data|dirty, cache_dirty_o=1, pop, done_o=1 -> IDLE.
- INVALIDATE: request port; on grant: write valid=0 at latched address -> IDLE. No done_o pulse.
- MEMORY_WRITE: bufferable: when !str_buf_full_i push, pop, done_o -> IDLE. Otherwise cpu_request_o=!ext_acknowledge_i; on ack pop, done_o -> IDLE. cache_data_o=head data.
- Byte lanes: size=2^width bytes (width 3 with PORT_BYTES=4 treated as word); offset = addr[log2(PORT_BYTES)-1:0] aligned down to size; byte_write = ((1<<size)-1)<<offset; data shifted left by 8*offset.
- Head cannot be killed once out of IDLE (spec already 0). Grant withheld: stay in current state holding requests.

Test Plan:
- Non-spec cachable word store 0x100, data 0xDEADBEEF, grant immediate, hit -> read cycle 0, write cycle 3 with byte_write=4'b1111, done_o cycle 3.
- Byte store addr 0x103, data 0xAB, hit -> byte_write=4'b1000, cache_data_o[31:24]=0xAB.
- Push 4 spec stores ID 1 -> stu_ready_o=0; resolve ID 1 kill -> four consecutive done_o pulses, no cache writes, idle_o=1.
- Spec store ID 2 followed by resolve with kill=0 in the same cycle as push -> processed normally.
- ext_invalidate_i with head store ready, hit -> invalidate served first, valid written 0, then store proceeds.
- Non-bufferable miss: cpu_request_o high 3 cycles until ext_acknowledge_i -> done_o; bufferable miss with str_buf_full_i=1 for 2 cycles -> push on cycle 3.
